valtrain_detector: RTL



---
 rtl/valtrain_detector.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/valtrain_detector.sv
// Receive-side valid-lane training checker: compares qualified RX valid words against a fixed pattern.
// Optional first-error capture (o_first_err_word/o_first_err_idx) is enabled with VALTRAIN_FIRST_ERR_EN.
module valtrain_detector #(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] PATTERN       = 32'hF0F0F0F0,
  parameter int unsigned           ITERATIONS    = 32,
  parameter int unsigned           ERR_THRESHOLD = 0,
  parameter int unsigned           CNT_W         = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable_detector,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_RVLD_L,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [CNT_W-1:0]      o_err_count
`ifdef VALTRAIN_FIRST_ERR_EN
  ,
  output logic [DATA_WIDTH-1:0] o_first_err_word,
  output logic [CNT_W-1:0]      o_first_err_idx
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] word_cnt, cnt_nxt, err_nxt, err_sat;
  logic             busy_nxt, done_nxt, pass_nxt, mismatch;
`ifdef VALTRAIN_FIRST_ERR_EN
  logic [DATA_WIDTH-1:0] fw_nxt;
  logic [CNT_W-1:0]      fi_nxt;
`endif

  function automatic logic within_thr(input logic [CNT_W-1:0] c);
    return 32'(c) <= ERR_THRESHOLD;
  endfunction

  assign mismatch = (i_RVLD_L != PATTERN);
  // error count pins at all-ones instead of wrapping
  assign err_sat  = (mismatch && (o_err_count != '1)) ? o_err_count + 1'b1 : o_err_count;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = word_cnt;
    err_nxt   = o_err_count;
    pass_nxt  = o_pass;
    busy_nxt  = o_busy;
    done_nxt  = o_done;
`ifdef VALTRAIN_FIRST_ERR_EN
    fw_nxt    = o_first_err_word;
    fi_nxt    = o_first_err_idx;
`endif
    if (i_clear) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      err_nxt   = '0;
      pass_nxt  = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
`ifdef VALTRAIN_FIRST_ERR_EN
      fw_nxt    = '0;
      fi_nxt    = '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (i_enable_detector) begin
          cnt_nxt  = CNT_W'(1);
          err_nxt  = CNT_W'(mismatch);
          pass_nxt = 1'b0;
`ifdef VALTRAIN_FIRST_ERR_EN
          fw_nxt   = mismatch ? i_RVLD_L : '0;
          fi_nxt   = '0;
`endif
          if (ITERATIONS == 1) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = within_thr(err_nxt);
          end else begin
            state_nxt = S_COMPARE;
            busy_nxt  = 1'b1;
          end
        end
        S_COMPARE: if (i_enable_detector) begin
          cnt_nxt = word_cnt + 1'b1;
          err_nxt = err_sat;
`ifdef VALTRAIN_FIRST_ERR_EN
          // a zero count means no mismatch has been seen yet in this run
          if (mismatch && (o_err_count == '0)) begin
            fw_nxt = i_RVLD_L;
            fi_nxt = word_cnt;
          end
`endif
          if (cnt_nxt == LAST) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = within_thr(err_nxt);
          end
        end
        S_DONE: if (!i_enable_detector) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b0;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      o_err_count <= '0;
      o_pass      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
`ifdef VALTRAIN_FIRST_ERR_EN
      o_first_err_word <= '0;
      o_first_err_idx  <= '0;
`endif
    end else begin
      state       <= state_nxt;
      word_cnt    <= cnt_nxt;
      o_err_count <= err_nxt;
      o_pass      <= pass_nxt;
      o_busy      <= busy_nxt;
      o_done      <= done_nxt;
`ifdef VALTRAIN_FIRST_ERR_EN
      o_first_err_word <= fw_nxt;
      o_first_err_idx  <= fi_nxt;
`endif
    end
  end

endmodule
